noise_injector: RTL and testbench
=================================

Name: noise_injector

Overview:
Downstream consumer of the pink noise generator output. Removes residual DC from the noise with a one-pole high-pass and scales it with a slew-limited gain. It then adds the scaled noise to an oscillator signal and saturates the sum. Runs at the 4 kHz sample strobe (clk_en) and feeds the oscillator/summing network.

Parameters:
WIDTH, 18, signed sample width of noise_in, signal_in and signal_out (Q4.14)
FRAC, 14, fractional bits of samples (informational; arithmetic is width-preserving)
GAIN_W, 16, unsigned gain width, Q0.GAIN_W (0 to 1-2^-GAIN_W)
RAMP_STEP, 64, gain change per clk_en strobe while ramping
DC_SHIFT, 8, DC-blocker pole: leak = acc >>> DC_SHIFT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clk_en  in  1  sample strobe; all state advances only when high (except target/mute capture)
noise_in  in  WIDTH  signed pink noise sample
signal_in  in  WIDTH  signed oscillator sample to which noise is added
gain_target  in  GAIN_W  requested noise gain
gain_load  in  1  one-cycle pulse; latch gain_target into tgt_r
mute  in  1  level; while high the effective target is 0
signal_out  out  WIDTH  signed saturated sum
out_valid  out  1  high for the clk cycle in which signal_out updates with a filled pipeline
ramp_busy  out  1  gain FSM not in IDLE
sat_flag  out  1  high while current signal_out is a clipped value

Behaviour:
- Reset clears everything:
  - outputs: signal_out, out_valid, ramp_busy, sat_flag all 0
  - internal state: dc_acc, hp_r, sig_r, gain_cur, tgt_r all 0; valid pipe 2'b00; FSM in IDLE
- clk_en low: all registers hold (gain_load and tgt_r capture still operate); out_valid is 0.
- Stage 1 (clk_en):
  - leak = dc_acc >>> DC_SHIFT
  - hp_r <= noise_in - leak, saturated to WIDTH
  - dc_acc (WIDTH+DC_SHIFT bits, signed) <= dc_acc + noise_in - leak
  - sig_r <= signal_in
- Stage 2 (clk_en):
  - prod = hp_r * {1'b0, gain_cur}, then prod >>> GAIN_W (arithmetic)
  - sum = prod + sig_r in WIDTH+1 bits
  - clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat_flag <= clamp occurred
- Latency: signal_out reflects inputs sampled 2 clk_en strobes earlier.
- out_valid = clk_en delayed one clk AND valid pipe full. It first asserts after the 2nd strobe following reset.
- Gain FSM (advances on clk_en): eff_tgt = mute ? 0 : tgt_r.
  - IDLE: gain_cur == eff_tgt. Go to UP if gain_cur < eff_tgt; go to DOWN if gain_cur > eff_tgt.
  - UP: gain_cur += RAMP_STEP. If the remaining distance is <= RAMP_STEP, snap to eff_tgt and go to IDLE.
  - DOWN: mirror of UP.
  - Direction is re-evaluated every strobe. A load or mute mid-ramp reverses direction with no pause step.
  - gain_cur never over- or undershoots eff_tgt and never wraps.
- gain_load coinciding with clk_en:
  - tgt_r updates this cycle.
  - The step in that same cycle uses the old tgt_r.
  - The new target governs from the next strobe.
- gain_cur used in stage 2 is its value before this strobe's step.
- Async reset mid-ramp: immediately returns to the reset state; no ramp resumes.

Optional Feature:
NOISE_INJ_DCBLOCK_EN
- Defined: DC blocker present as above.
- Undefined: hp_r <= noise_in directly; dc_acc is not instantiated.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Package noise_inj_pkg:
  - FSM state enum (IDLE, UP, DOWN)
  - default WIDTH/FRAC/GAIN_W constants
  - SAT_MAX/SAT_MIN localparams derived from WIDTH
  - saturate function
- Sub-module noise_gain_ramp:
  - contains tgt_r, mute handling, the FSM and gain_cur
  - outputs gain_cur and ramp_busy
- Top level holds the two data stages and output registers.

Test Plan:
- Reset, gain 0, signal_in=1000, random noise_in -> signal_out=1000 from the 2nd strobe onward; out_valid pulses once per strobe; sat_flag=0.
- gain_load with gain_target=16'h8000 at gain 0 -> ramp_busy high for exactly 512 strobes. gain_cur steps 64 per strobe, ends at 32768 exactly, then FSM returns to IDLE.
- DCBLOCK off, noise_in=4096, gain 16'hFFFF settled, signal_in=0 -> signal_out=4095. DCBLOCK on with the same stimulus -> output decays monotonically toward 0 and is below 64 after 2048 strobes.
- signal_in=131000, noise_in=16384, gain 16'h8000 settled, DCBLOCK off -> signal_out=131071, sat_flag=1. signal_in=-131000, noise_in=-16384 -> signal_out=-131072, sat_flag=1.
- Ramp toward 32768, assert mute at gain_cur=16384 -> DOWN reaches 0 in 256 strobes. Deassert mute -> UP back to 32768 in 512 strobes.
- gain_load coincident with clk_en, and async rst asserted mid-ramp:
  - coincident load -> one step taken toward the old target, new target applied from the next strobe
  - rst mid-ramp -> all outputs 0 at once; gain_cur stays 0 after rst release

Source files
------------

// File: rtl/noise_injector_pkg.sv
// noise_inj_pkg: shared constants, gain FSM state type and the sample saturator.
package noise_inj_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN} ramp_state_e;
  localparam int DEF_WIDTH = 18;
  localparam int DEF_FRAC = 14;
  localparam int DEF_GAIN_W = 16;
  localparam logic signed [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic signed [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
  // Clamp a sign-extended value into the range of a w-bit signed sample.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return v > mx ? mx : v < mn ? mn : v;
  endfunction
endpackage

// File: rtl/noise_injector_if.sv
// noise_injector_if: sample, gain-control and status bundle of the noise injector.
interface noise_injector_if import noise_inj_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAIN_W = DEF_GAIN_W
);
  logic clk_en;
  logic signed [WIDTH-1:0] noise_in;
  logic signed [WIDTH-1:0] signal_in;
  logic [GAIN_W-1:0] gain_target;
  logic gain_load;
  logic mute;
  logic signed [WIDTH-1:0] signal_out;
  logic out_valid;
  logic ramp_busy;
  logic sat_flag;
  modport master (
    output clk_en, noise_in, signal_in, gain_target, gain_load, mute,
    input signal_out, out_valid, ramp_busy, sat_flag
  );
  modport slave (
    input clk_en, noise_in, signal_in, gain_target, gain_load, mute,
    output signal_out, out_valid, ramp_busy, sat_flag
  );
endinterface

// File: rtl/noise_injector_gain_ramp.sv
// noise_gain_ramp: slew-limited noise gain; steps toward the (mute-aware) target once per strobe.
module noise_gain_ramp import noise_inj_pkg::*; #(
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int RAMP_STEP = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en_i,
  input  logic [GAIN_W-1:0] gain_target_i,
  input  logic gain_load_i,
  input  logic mute_i,
  output logic [GAIN_W-1:0] gain_cur_o,
  output logic ramp_busy_o
);
  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);
  ramp_state_e state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d, tgt_q, eff, up_dist, dn_dist;
  logic lt, gt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      gain_q <= '0;
      tgt_q <= '0;
    end else begin
      state_q <= state_d;
      gain_q <= gain_d;
      if (gain_load_i) tgt_q <= gain_target_i;
    end
  // Ramping states re-evaluate direction every strobe; the final step snaps to the target.
  always_comb begin
    eff = mute_i ? '0 : tgt_q;
    lt = gain_q < eff;
    gt = gain_q > eff;
    up_dist = eff - gain_q;
    dn_dist = gain_q - eff;
    state_d = state_q;
    gain_d = gain_q;
    if (clk_en_i && state_q == IDLE) state_d = lt ? UP : gt ? DOWN : IDLE;
    else if (clk_en_i) begin
      state_d = (lt && up_dist > STEP) ? UP : (gt && dn_dist > STEP) ? DOWN : IDLE;
      gain_d = lt ? (up_dist > STEP ? gain_q + STEP : eff) : gt ? (dn_dist > STEP ? gain_q - STEP : eff) : gain_q;
    end
  end
  always_comb begin
    gain_cur_o = gain_q;
    ramp_busy_o = state_q != IDLE;
  end
endmodule

// File: rtl/noise_injector.sv
// noise_injector: DC-blocked, gain-ramped noise added to an oscillator sample with saturation.
// Define NOISE_INJ_DCBLOCK_EN to include the one-pole DC blocker on the noise path.
module noise_injector import noise_inj_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC = DEF_FRAC,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int RAMP_STEP = 64,
  parameter int DC_SHIFT = 8
) (
  input logic clk,
  input logic rst,
  noise_injector_if.slave bus
);
  logic [GAIN_W-1:0] gain_cur;
  logic signed [WIDTH-1:0] hp_q, hp_d, sig_q, out_q, out_d;
  logic signed [WIDTH+GAIN_W:0] prod;
  logic signed [WIDTH:0] sum;
  logic sat_q, sat_d, en_q;
  logic [1:0] vld_q;
  if (FRAC >= WIDTH) begin : g_cfg_err
    $error("noise_injector: FRAC must be below WIDTH");
  end
  noise_gain_ramp #(.GAIN_W(GAIN_W), .RAMP_STEP(RAMP_STEP)) u_ramp (
    .clk(clk),
    .rst(rst),
    .clk_en_i(bus.clk_en),
    .gain_target_i(bus.gain_target),
    .gain_load_i(bus.gain_load),
    .mute_i(bus.mute),
    .gain_cur_o(gain_cur),
    .ramp_busy_o(bus.ramp_busy)
  );
`ifdef NOISE_INJ_DCBLOCK_EN
  logic signed [WIDTH+DC_SHIFT-1:0] acc_q, acc_d, leak;
  logic signed [WIDTH:0] diff;
  always_comb begin
    leak = acc_q >>> DC_SHIFT;
    diff = (WIDTH+1)'(bus.noise_in) - (WIDTH+1)'(leak);
    hp_d = WIDTH'(saturate(64'(diff), WIDTH));
    acc_d = acc_q + (WIDTH+DC_SHIFT)'(bus.noise_in) - leak;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else if (bus.clk_en) acc_q <= acc_d;
`else
  assign hp_d = bus.noise_in;
`endif
  // Gain is unsigned Q0.GAIN_W, so the scaled noise always fits back into WIDTH bits.
  always_comb begin
    prod = hp_q * $signed({1'b0, gain_cur});
    sum = (WIDTH+1)'(prod >>> GAIN_W) + (WIDTH+1)'(sig_q);
    out_d = WIDTH'(saturate(64'(sum), WIDTH));
    sat_d = 64'(sum) != saturate(64'(sum), WIDTH);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hp_q <= '0;
      sig_q <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
      vld_q <= 2'b00;
      en_q <= 1'b0;
    end else begin
      en_q <= bus.clk_en;
      if (bus.clk_en) begin
        hp_q <= hp_d;
        sig_q <= bus.signal_in;
        out_q <= out_d;
        sat_q <= sat_d;
        vld_q <= {vld_q[0], 1'b1};
      end
    end
  assign bus.signal_out = out_q;
  assign bus.sat_flag = sat_q;
  assign bus.out_valid = en_q & vld_q[1];
endmodule

// File: tb/tb_noise_injector.sv
// tb_noise_injector: directed vectors and ramp/reset sequences for noise_injector.
module tb_noise_injector;
  import noise_inj_pkg::*;
  typedef struct {
    int noise;
    int sig;
    int gain;
    int exp_out;
    int exp_sat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  noise_injector_if bus ();
  noise_injector dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic strobe();
    bus.clk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.clk_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int g);
    bus.gain_target = 16'(g);
    bus.gain_load = 1'b1;
    @(posedge clk);
    #1;
    bus.gain_load = 1'b0;
  endtask

  task automatic settle(input string name, output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    do begin
      strobe();
      n++;
      if (bus.ramp_busy) busy_cnt++;
    end while (bus.ramp_busy && n < 2000);
    if (n >= 2000) chk({name, "_timeout"}, n, 0);
  endtask

  initial begin
    vec_t vecs[12];
    int bc;
    int prev;
    logic mono;
    vecs[0] = '{4096, 0, 'hFFFF, 4095, 0};
    vecs[1] = '{16384, 131000, 'h8000, int'(SAT_MAX), 1};
    vecs[2] = '{-16384, -131000, 'h8000, int'(SAT_MIN), 1};
    vecs[3] = '{65536, 0, 'h8000, 32768, 0};
    vecs[4] = '{-65536, 100, 'h4000, -16284, 0};
    vecs[5] = '{1000, -500, 0, -500, 0};
    vecs[6] = '{131071, 0, 'hFFFF, 131069, 0};
    vecs[7] = '{-131072, -1, 'hFFFF, -131071, 0};
    vecs[8] = '{-131072, -2, 'hFFFF, -131072, 0};
    vecs[9] = '{131071, 3, 'hFFFF, 131071, 1};
    vecs[10] = '{3, -7, 'h8000, -6, 0};
    vecs[11] = '{-3, 0, 'h8000, -2, 0};
    bus.clk_en = 1'b0;
    bus.noise_in = '0;
    bus.signal_in = '0;
    bus.gain_target = '0;
    bus.gain_load = 1'b0;
    bus.mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", bus.signal_out, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.ramp_busy, 0);
    chk("rst_sat", bus.sat_flag, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Gain 0: output is the oscillator sample two strobes late, valid from strobe 2.
    bus.signal_in = 18'sd1000;
    for (int i = 1; i <= 8; i++) begin
      bus.noise_in = 18'($urandom);
      bus.clk_en = 1'b1;
      @(posedge clk);
      #1;
      bus.clk_en = 1'b0;
      chk($sformatf("lat_valid%0d", i), bus.out_valid, i >= 2 ? 1 : 0);
      chk($sformatf("lat_out%0d", i), $signed(bus.signal_out), i >= 2 ? 1000 : 0);
      chk($sformatf("lat_sat%0d", i), bus.sat_flag, 0);
      @(posedge clk);
      #1;
      chk($sformatf("lat_valid_gap%0d", i), bus.out_valid, 0);
    end
    // Ramp 0 -> 32768.
    load('h8000);
    bc = 0;
    for (int n = 1; n <= 600; n++) begin
      strobe();
      if (bus.ramp_busy) bc++;
      if (n == 101) chk("ramp_mid_gain", dut.gain_cur, 6400);
      if (!bus.ramp_busy) break;
    end
    chk("ramp_busy_strobes", bc, 512);
    chk("ramp_end_gain", dut.gain_cur, 32768);
    // Mute mid-ramp.
    load(0);
    settle("to_zero", bc);
    chk("to_zero_gain", dut.gain_cur, 0);
    load('h8000);
    repeat (257) strobe();
    chk("mute_start_gain", dut.gain_cur, 16384);
    bus.mute = 1'b1;
    repeat (255) strobe();
    chk("mute_255_gain", dut.gain_cur, 64);
    chk("mute_255_busy", bus.ramp_busy, 1);
    strobe();
    chk("mute_256_gain", dut.gain_cur, 0);
    chk("mute_256_busy", bus.ramp_busy, 0);
    bus.mute = 1'b0;
    settle("unmute", bc);
    chk("unmute_busy_strobes", bc, 512);
    chk("unmute_gain", dut.gain_cur, 32768);
    // Load coincident with a strobe: that step still follows the old target.
    load(0);
    repeat (11) strobe();
    chk("coin_pre_gain", dut.gain_cur, 32128);
    bus.gain_target = 16'hFFFF;
    bus.gain_load = 1'b1;
    bus.clk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.gain_load = 1'b0;
    bus.clk_en = 1'b0;
    @(posedge clk);
    #1;
    chk("coin_step_old", dut.gain_cur, 32064);
    strobe();
    chk("coin_step_new", dut.gain_cur, 32128);
    settle("coin_settle", bc);
    chk("coin_settle_gain", dut.gain_cur, 65535);
`ifdef NOISE_INJ_DCBLOCK_EN
    bus.noise_in = '0;
    bus.signal_in = '0;
    repeat (4) strobe();
    bus.noise_in = 18'sd4096;
    strobe();
    strobe();
    chk("dc_first", $signed(bus.signal_out), 4095);
    prev = $signed(bus.signal_out);
    mono = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      strobe();
      if ($signed(bus.signal_out) > prev) mono = 1'b0;
      prev = $signed(bus.signal_out);
    end
    chk("dc_monotonic", mono, 1);
    chk("dc_below_64", prev < 64, 1);
`else
    prev = 0;
    mono = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.noise_in = 18'(vecs[i].noise);
      bus.signal_in = 18'(vecs[i].sig);
      load(vecs[i].gain);
      settle($sformatf("vec%0d_settle", i), bc);
      strobe();
      strobe();
      chk($sformatf("vec%0d_out", i), $signed(bus.signal_out), vecs[i].exp_out);
      chk($sformatf("vec%0d_sat", i), bus.sat_flag, vecs[i].exp_sat);
    end
`endif
    // Asynchronous reset in the middle of a ramp.
    bus.noise_in = '0;
    bus.signal_in = 18'sd1000;
    load(0);
    settle("pre_rst", bc);
    load('hFFFF);
    repeat (50) strobe();
    chk("pre_rst_busy", bus.ramp_busy, 1);
    chk("pre_rst_out", $signed(bus.signal_out), 1000);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", bus.signal_out, 0);
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_busy", bus.ramp_busy, 0);
    chk("arst_sat", bus.sat_flag, 0);
    chk("arst_gain", dut.gain_cur, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) strobe();
    chk("post_rst_gain", dut.gain_cur, 0);
    chk("post_rst_busy", bus.ramp_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
